// File: rtl/ps2_pkg.sv
// Shared PS/2 set-2 definitions: special byte values, tracker states and the
// scan-code to letter-index lookup used by the key status tracker.
package ps2_pkg;

    localparam logic [7:0] SC_BREAK    = 8'hF0;
    localparam logic [7:0] SC_EXTEND   = 8'hE0;
    localparam logic [7:0] SC_PAUSE    = 8'hE1;
    localparam logic [7:0] SC_BAT_OK   = 8'hAA;
    localparam logic [7:0] SC_ACK      = 8'hFA;
    localparam logic [7:0] SC_ECHO     = 8'hEE;
    localparam logic [7:0] SC_RESEND   = 8'hFE;
    localparam logic [7:0] SC_OVERRUN0 = 8'h00;
    localparam logic [7:0] SC_OVERRUNF = 8'hFF;

    localparam logic [2:0] PAUSE_SKIP  = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_BRK     = 3'd1,
        ST_EXT     = 3'd2,
        ST_EXT_BRK = 3'd3,
        ST_PAUSE   = 3'd4
    } ps2_state_t;

    // Returns {hit, letter index}; index 0 = A ... 25 = Z.
    function automatic logic [5:0] scan_to_letter(input logic [7:0] code);
        logic [5:0] r;
        case (code)
            8'h1C: r = {1'b1, 5'd0};
            8'h32: r = {1'b1, 5'd1};
            8'h21: r = {1'b1, 5'd2};
            8'h23: r = {1'b1, 5'd3};
            8'h24: r = {1'b1, 5'd4};
            8'h2B: r = {1'b1, 5'd5};
            8'h34: r = {1'b1, 5'd6};
            8'h33: r = {1'b1, 5'd7};
            8'h43: r = {1'b1, 5'd8};
            8'h3B: r = {1'b1, 5'd9};
            8'h42: r = {1'b1, 5'd10};
            8'h4B: r = {1'b1, 5'd11};
            8'h3A: r = {1'b1, 5'd12};
            8'h31: r = {1'b1, 5'd13};
            8'h44: r = {1'b1, 5'd14};
            8'h4D: r = {1'b1, 5'd15};
            8'h15: r = {1'b1, 5'd16};
            8'h2D: r = {1'b1, 5'd17};
            8'h1B: r = {1'b1, 5'd18};
            8'h2C: r = {1'b1, 5'd19};
            8'h3C: r = {1'b1, 5'd20};
            8'h2A: r = {1'b1, 5'd21};
            8'h1D: r = {1'b1, 5'd22};
            8'h22: r = {1'b1, 5'd23};
            8'h35: r = {1'b1, 5'd24};
            8'h1A: r = {1'b1, 5'd25};
            default: r = 6'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ps2_prefix_timer.sv
// Watchdog for a pending scan-code prefix: counts while run is high and
// pulses expire on the last count so the tracker can abandon the prefix.
module ps2_prefix_timer #(
    parameter int TIMEOUT_CYCLES = 2_500_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic run,
    output logic expire
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] cnt;

    // Expiry returns the count to zero, so the counter never wraps.
    assign expire = run && (cnt == LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr || expire || !run) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + TW'(1);
        end
    end

endmodule

// File: rtl/ps2_key_status_tracker.sv
// Converts PS/2 set-2 bytes into a held-key vector for letters A-Z and emits
// one event per real press/release; prefixes are tracked by a small FSM.
module ps2_key_status_tracker
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 2_500_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        scan_valid,
    input  logic [7:0]  scan_code,
    input  logic        clear_all,
    output logic [25:0] key_status,
    output logic        evt_valid,
    output logic [4:0]  evt_key,
    output logic        evt_make,
    output logic        any_key
);

    ps2_state_t  state, state_n;
    logic [2:0]  skip_cnt, skip_n;
    logic [25:0] keys_n;
    logic        evt_valid_n, evt_make_n;
    logic [4:0]  evt_key_n;
    logic [5:0]  lut;
    logic        expire;

    ps2_prefix_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (clear_all || scan_valid),
        .run     (state != ST_IDLE),
        .expire  (expire)
    );

    assign lut = scan_to_letter(scan_code);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            skip_cnt   <= '0;
            key_status <= '0;
            evt_valid  <= 1'b0;
            evt_key    <= '0;
            evt_make   <= 1'b0;
            any_key    <= 1'b0;
        end else begin
            state      <= state_n;
            skip_cnt   <= skip_n;
            key_status <= keys_n;
            evt_valid  <= evt_valid_n;
            evt_key    <= evt_key_n;
            evt_make   <= evt_make_n;
            any_key    <= |keys_n;
        end
    end

    always_comb begin
        state_n     = state;
        skip_n      = skip_cnt;
        keys_n      = key_status;
        evt_valid_n = 1'b0;
        evt_key_n   = evt_key;
        evt_make_n  = evt_make;

        if (clear_all) begin
            state_n = ST_IDLE;
            skip_n  = '0;
            keys_n  = '0;
        end else if (scan_valid) begin
            // Overrun and controller status bytes resynchronise from any state.
            if (scan_code == SC_OVERRUN0 || scan_code == SC_OVERRUNF) begin
                state_n = ST_IDLE;
                skip_n  = '0;
                keys_n  = '0;
            end else if (scan_code == SC_BAT_OK || scan_code == SC_ACK ||
                         scan_code == SC_ECHO   || scan_code == SC_RESEND) begin
                state_n = ST_IDLE;
                skip_n  = '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (scan_code == SC_BREAK) begin
                            state_n = ST_BRK;
                        end else if (scan_code == SC_EXTEND) begin
                            state_n = ST_EXT;
                        end else if (scan_code == SC_PAUSE) begin
                            state_n = ST_PAUSE;
                            skip_n  = PAUSE_SKIP;
                        end else if (lut[5] && !key_status[lut[4:0]]) begin
                            keys_n[lut[4:0]] = 1'b1;
                            evt_valid_n      = 1'b1;
                            evt_key_n        = lut[4:0];
                            evt_make_n       = 1'b1;
                        end
                    end
                    ST_BRK: begin
                        state_n = ST_IDLE;
                        if (lut[5] && key_status[lut[4:0]]) begin
                            keys_n[lut[4:0]] = 1'b0;
                            evt_valid_n      = 1'b1;
                            evt_key_n        = lut[4:0];
                            evt_make_n       = 1'b0;
                        end
                    end
                    ST_EXT: begin
                        state_n = (scan_code == SC_BREAK) ? ST_EXT_BRK : ST_IDLE;
                    end
                    ST_PAUSE: begin
                        skip_n = (skip_cnt == 3'd0) ? 3'd0 : skip_cnt - 3'd1;
                        if (skip_cnt <= 3'd1) begin
                            state_n = ST_IDLE;
                        end
                    end
                    default: begin
                        state_n = ST_IDLE;
                    end
                endcase
            end
        end else if (expire) begin
            state_n = ST_IDLE;
            skip_n  = '0;
        end
    end

endmodule

// File: tb/tb_ps2_key_status_tracker.sv
// Directed bench for ps2_key_status_tracker with a short prefix timeout.
module tb_ps2_key_status_tracker;

    logic        clk;
    logic        reset_n;
    logic        scan_valid;
    logic [7:0]  scan_code;
    logic        clear_all;
    logic [25:0] key_status;
    logic        evt_valid;
    logic [4:0]  evt_key;
    logic        evt_make;
    logic        any_key;

    int checks   = 0;
    int failures = 0;
    int evt_cnt  = 0;
    int snap;

    ps2_key_status_tracker #(.TIMEOUT_CYCLES(16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .scan_valid (scan_valid),
        .scan_code  (scan_code),
        .clear_all  (clear_all),
        .key_status (key_status),
        .evt_valid  (evt_valid),
        .evt_key    (evt_key),
        .evt_make   (evt_make),
        .any_key    (any_key)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (evt_valid === 1'b1) evt_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample just after the capturing edge.
    task automatic cyc(input logic sv, input logic [7:0] code, input logic ca);
        @(negedge clk);
        scan_valid = sv;
        scan_code  = code;
        clear_all  = ca;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] code);
        cyc(1'b1, code, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0);
    endtask

    task automatic check_evt(input string tag, input logic v, input logic [4:0] k, input logic m);
        check({tag, "_valid"}, 32'(evt_valid), 32'(v));
        if (v) begin
            check({tag, "_key"}, 32'(evt_key), 32'(k));
            check({tag, "_make"}, 32'(evt_make), 32'(m));
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        scan_valid = 1'b0;
        scan_code  = 8'h00;
        clear_all  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_keys", 32'(key_status), 32'h0);
        check("rst_evt_valid", 32'(evt_valid), 32'h0);
        check("rst_evt_key", 32'(evt_key), 32'h0);
        check("rst_evt_make", 32'(evt_make), 32'h0);
        check("rst_any", 32'(any_key), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Press W, then typematic repeats
        send(8'h1D);
        check("w_keys", 32'(key_status), 32'h400000);
        check_evt("w_evt", 1'b1, 5'd22, 1'b1);
        check("w_any", 32'(any_key), 32'h1);
        send(8'h1D);
        check_evt("rep1_evt", 1'b0, 5'd0, 1'b0);
        send(8'h1D);
        check_evt("rep2_evt", 1'b0, 5'd0, 1'b0);
        check("rep_keys", 32'(key_status), 32'h400000);

        // Release W
        send(8'hF0);
        check_evt("f0_evt", 1'b0, 5'd0, 1'b0);
        check("f0_keys", 32'(key_status), 32'h400000);
        send(8'h1D);
        check("wrel_keys", 32'(key_status), 32'h0);
        check_evt("wrel_evt", 1'b1, 5'd22, 1'b0);
        check("wrel_any", 32'(any_key), 32'h0);

        // A then S back-to-back
        send(8'h1C);
        check("a_keys", 32'(key_status), 32'h000001);
        check_evt("a_evt", 1'b1, 5'd0, 1'b1);
        send(8'h1B);
        check("as_keys", 32'(key_status), 32'h040001);
        check_evt("s_evt", 1'b1, 5'd18, 1'b1);
        idle(1);
        check("hold_valid", 32'(evt_valid), 32'h0);
        check("hold_key", 32'(evt_key), 32'd18);
        check("hold_make", 32'(evt_make), 32'h1);
        send(8'hF0); send(8'h1C); send(8'hF0); send(8'h1B);
        check("as_rel_keys", 32'(key_status), 32'h0);

        // Extended sequences are discarded
        idle(1);
        snap = evt_cnt;
        send(8'hE0); send(8'h1D);
        send(8'hE0); send(8'hF0); send(8'h1D);
        idle(1);
        check("ext_keys", 32'(key_status), 32'h0);
        check("ext_no_evt", 32'(evt_cnt), 32'(snap));
        send(8'h1D);
        check("ext_then_w", 32'(key_status), 32'h400000);
        check_evt("ext_then_w_evt", 1'b1, 5'd22, 1'b1);
        send(8'hF0); send(8'h1D);
        check("ext_w_rel", 32'(key_status), 32'h0);

        // Pause sequence skipped, trailing D pressed
        idle(1);
        snap = evt_cnt;
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        idle(1);
        check("pause_no_evt", 32'(evt_cnt), 32'(snap));
        send(8'h23);
        check("pause_d_keys", 32'(key_status), 32'h000008);
        check_evt("pause_d_evt", 1'b1, 5'd3, 1'b1);

        // Exactly seven bytes skipped after E1
        send(8'hE1);
        for (int i = 0; i < 7; i++) send(8'h1C);
        check("skip7_keys", 32'(key_status), 32'h000008);
        send(8'h1B);
        check("skip7_s_keys", 32'(key_status), 32'h040008);

        // Timeout abandons a pending break
        send(8'hF0);
        idle(16);
        send(8'h1C);
        check("tmo_keys", 32'(key_status), 32'h040009);
        check_evt("tmo_evt", 1'b1, 5'd0, 1'b1);
        send(8'hF0);
        idle(14);
        send(8'h1B);
        check("no_tmo_keys", 32'(key_status), 32'h000009);
        check_evt("no_tmo_evt", 1'b1, 5'd18, 1'b0);

        // Overrun byte drops all keys silently
        idle(1);
        snap = evt_cnt;
        send(8'hFF);
        check("ovr_keys", 32'(key_status), 32'h0);
        check("ovr_valid", 32'(evt_valid), 32'h0);
        check("ovr_any", 32'(any_key), 32'h0);
        idle(1);
        check("ovr_no_evt", 32'(evt_cnt), 32'(snap));

        // clear_all wins over a simultaneous F0
        send(8'h1D);
        check("clr_w_keys", 32'(key_status), 32'h400000);
        cyc(1'b1, 8'hF0, 1'b1);
        check("clr_keys", 32'(key_status), 32'h0);
        check("clr_valid", 32'(evt_valid), 32'h0);
        send(8'h1D);
        check("clr_then_w", 32'(key_status), 32'h400000);
        check_evt("clr_then_w_evt", 1'b1, 5'd22, 1'b1);

        // Reset after F0 discards the prefix
        send(8'hF0);
        @(negedge clk);
        scan_valid = 1'b0;
        reset_n    = 1'b0;
        #2;
        check("arst_keys", 32'(key_status), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        send(8'h1D);
        check("arst_w_keys", 32'(key_status), 32'h400000);
        check_evt("arst_w_evt", 1'b1, 5'd22, 1'b1);

        // Status byte AA cancels a pending break
        send(8'hF0); send(8'hAA); send(8'h1C);
        check("aa_keys", 32'(key_status), 32'h400001);
        check_evt("aa_evt", 1'b1, 5'd0, 1'b1);

        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
